// File: rtl/alu_seq_pkg.sv
// Shared codes and types for the 6502 ALU sequencer.
// ALU op codes, destination codes, SR bit indices, FSM states.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_INC = 4'd5;
    localparam logic [3:0] OP_DEC = 4'd6;
    localparam logic [3:0] OP_TST = 4'd15;

    localparam logic [2:0] DST_NONE = 3'd0;
    localparam logic [2:0] DST_A    = 3'd1;
    localparam logic [2:0] DST_X    = 3'd2;
    localparam logic [2:0] DST_Y    = 3'd3;
    localparam logic [2:0] DST_S    = 3'd4;
    localparam logic [2:0] DST_MEM  = 3'd5;

    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_I = 2;
    localparam int SR_D = 3;
    localparam int SR_B = 4;
    localparam int SR_V = 6;
    localparam int SR_N = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EXEC,
        ST_WB,
        ST_WR
    } state_t;

    typedef struct packed {
        logic       rd;
        logic [2:0] dst;
        logic [7:0] fmask;
    } cmd_t;

    function automatic logic dst_is_reg(input logic [2:0] dst);
        return (dst == DST_A) || (dst == DST_X) ||
               (dst == DST_Y) || (dst == DST_S);
    endfunction

    function automatic logic [1:0] dst_reg(input logic [2:0] dst);
        return 2'(dst - DST_A);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command handshake from the decoder and memory bus port of alu_seq.
// master = decoder/bus side, slave = alu_seq.
interface alu_seq_if #(
    parameter int ADDR_W = 16
);
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [1:0]        cmd_sel;
    logic              cmd_mem;
    logic [7:0]        cmd_imm;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_dst;
    logic [7:0]        cmd_fmask;
    logic              cmd_done;
    logic              cmd_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_mem,
        output cmd_imm, cmd_addr, cmd_dst, cmd_fmask,
        input  cmd_ready, cmd_done, cmd_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_mem,
        input  cmd_imm, cmd_addr, cmd_dst, cmd_fmask,
        output cmd_ready, cmd_done, cmd_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

endinterface

// File: rtl/alu_seq_sr_merge.sv
// Masked status-register merge: bits set in fmask take the ALU flag,
// the rest keep the current SR value.
module alu_seq_sr_merge (
    input  logic [7:0] sr_in,
    input  logic [7:0] alu_sr,
    input  logic [7:0] fmask,
    output logic [7:0] sr_out
);

    assign sr_out = (sr_in & ~fmask) | (alu_sr & fmask);

endmodule

// File: rtl/alu_seq.sv
// 6502 ALU sequencer: operand fetch, ALU drive, register/memory/SR writeback.
// Define ALU_SEQ_RMW_EN for the read-modify-write dummy write on DST_MEM.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MEM_TMO = 15
) (
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_sel,
    output logic [7:0]  alu_din,
    input  logic [7:0]  alu_dout,
    input  logic [7:0]  alu_sr,
    input  logic [7:0]  sr_in,
    output logic        sr_we,
    output logic [7:0]  sr_wdata,
    output logic        reg_we,
    output logic [1:0]  reg_waddr,
    output logic [7:0]  reg_wdata
);

`ifdef ALU_SEQ_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    localparam int TW = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);

    state_t            state;
    state_t            state_nx;
    cmd_t              cmd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        res;
    logic [7:0]        res_sr;
    logic [TW-1:0]     tmo_cnt;
    logic              rmw_first;

    logic              accept;
    logic              in_bus;
    logic              ack;
    logic              tmo_hit;
    logic [7:0]        sr_merged;

    logic              cmd_ready;
    logic              cmd_done;
    logic              cmd_err;
    logic              mem_req;
    logic              mem_we;
    logic [7:0]        mem_wdata;

    assign accept  = (state == ST_IDLE) && bus.cmd_valid;
    assign in_bus  = (state == ST_RD) || (state == ST_WR);
    assign ack     = in_bus && bus.mem_ack;
    // Zero MEM_TMO disables the abort and lets the bus stall forever.
    assign tmo_hit = (MEM_TMO != 0) && in_bus && !bus.mem_ack &&
                     (tmo_cnt == TMO_LAST);

    alu_seq_sr_merge u_sr_merge (
        .sr_in  (sr_in),
        .alu_sr (res_sr),
        .fmask  (cmd.fmask),
        .sr_out (sr_merged)
    );

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        cmd_err   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        reg_we    = 1'b0;
        reg_waddr = 2'd0;
        reg_wdata = 8'd0;
        sr_we     = 1'b0;
        sr_wdata  = 8'd0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nx = bus.cmd_mem ? ST_RD : ST_EXEC;
                end
            end
            ST_RD: begin
                mem_req = 1'b1;
                if (ack) begin
                    state_nx = ST_EXEC;
                end else if (tmo_hit) begin
                    state_nx = ST_IDLE;
                    cmd_done = 1'b1;
                    cmd_err  = 1'b1;
                end
            end
            ST_EXEC: begin
                state_nx = ST_WB;
            end
            ST_WB: begin
                reg_we = dst_is_reg(cmd.dst);
                sr_we  = |cmd.fmask;
                if (reg_we) begin
                    reg_waddr = dst_reg(cmd.dst);
                    reg_wdata = res;
                end
                if (sr_we) begin
                    sr_wdata = sr_merged;
                end
                if (cmd.dst == DST_MEM) begin
                    state_nx = ST_WR;
                end else begin
                    state_nx = ST_IDLE;
                    cmd_done = 1'b1;
                end
            end
            ST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = rmw_first ? din : res;
                if (ack) begin
                    if (!rmw_first) begin
                        state_nx = ST_IDLE;
                        cmd_done = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nx = ST_IDLE;
                    cmd_done = 1'b1;
                    cmd_err  = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            addr      <= '0;
            din       <= 8'd0;
            res       <= 8'd0;
            res_sr    <= 8'd0;
            tmo_cnt   <= '0;
            rmw_first <= 1'b0;
            alu_op    <= OP_TST;
            alu_sel   <= 2'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cmd     <= '{rd: bus.cmd_mem,
                             dst: bus.cmd_dst,
                             fmask: bus.cmd_fmask};
                addr    <= bus.cmd_addr;
                alu_op  <= bus.cmd_op;
                alu_sel <= bus.cmd_sel;
                if (!bus.cmd_mem) begin
                    din <= bus.cmd_imm;
                end
            end
            if ((state == ST_RD) && bus.mem_ack) begin
                din <= bus.mem_rdata;
            end
            // ALU result settles after its negedge latch within EXEC.
            if (state == ST_EXEC) begin
                res    <= alu_dout;
                res_sr <= alu_sr;
            end
            if (!in_bus || ack) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (state == ST_WB) begin
                rmw_first <= RMW_EN && cmd.rd && (cmd.dst == DST_MEM);
            end else if (ack) begin
                rmw_first <= 1'b0;
            end
        end
    end

    assign alu_din       = din;
    assign bus.cmd_ready = cmd_ready;
    assign bus.cmd_done  = cmd_done;
    assign bus.cmd_err   = cmd_err;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq with a behavioural ALU and bus.
// Build with ALU_SEQ_RMW_EN to expect the RMW dummy write.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int MEM_TMO = 15;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
    } rexp_t;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
    } mexp_t;

    typedef struct {
        logic err;
        int   cyc;
    } dexp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_op;
    logic [1:0] alu_sel;
    logic [7:0] alu_din;
    logic [7:0] alu_dout;
    logic [7:0] alu_sr;
    logic [7:0] sr_in;
    logic       sr_we;
    logic [7:0] sr_wdata;
    logic       reg_we;
    logic [1:0] reg_waddr;
    logic [7:0] reg_wdata;

    logic [7:0] regs [4];
    logic [3:0] m_op;
    logic [7:0] m_a;
    logic [7:0] m_din;
    logic       m_c;
    logic [8:0] sum;
    logic [7:0] out;
    logic       c_f;
    logic       v_f;

    rexp_t      q_reg [$];
    logic [7:0] q_sr [$];
    mexp_t      q_mem [$];
    dexp_t      q_done [$];

    int checks = 0;
    int errors = 0;
    int n_req;

    always #5 clk = ~clk;

    alu_seq_if #(.ADDR_W(ADDR_W)) bus ();

    alu_seq #(
        .ADDR_W  (ADDR_W),
        .MEM_TMO (MEM_TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .alu_op    (alu_op),
        .alu_sel   (alu_sel),
        .alu_din   (alu_din),
        .alu_dout  (alu_dout),
        .alu_sr    (alu_sr),
        .sr_in     (sr_in),
        .sr_we     (sr_we),
        .sr_wdata  (sr_wdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata)
    );

    // Behavioural ALU: latches controls on negedge, result combinational.
    always @(negedge clk) begin
        m_op  <= alu_op;
        m_a   <= regs[alu_sel];
        m_din <= alu_din;
        m_c   <= sr_in[SR_C];
    end

    always_comb begin
        sum = 9'd0;
        out = m_din;
        c_f = m_c;
        v_f = 1'b0;
        case (m_op)
            OP_ADD: begin
                sum = {1'b0, m_a} + {1'b0, m_din} + {8'd0, m_c};
                out = sum[7:0];
                c_f = sum[8];
                v_f = (m_a[7] == m_din[7]) && (out[7] != m_a[7]);
            end
            OP_INC: out = m_din + 8'd1;
            default: ;
        endcase
        alu_dout = out;
        alu_sr   = {out[7], v_f, 4'hF, out == 8'd0, c_f};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(
        input  logic [3:0]  op,
        input  logic [1:0]  sel,
        input  logic        rd,
        input  logic [7:0]  imm,
        input  logic [15:0] addr,
        input  logic [2:0]  dst,
        input  logic [7:0]  fmask,
        input  int          lat,
        input  logic [7:0]  rdata,
        input  bit          hold,
        input  bit          noise,
        output int          nreq
    );
        int    req_cnt;
        bit    done;
        bit    ack;
        rexp_t r;
        mexp_t m;
        dexp_t d;
        req_cnt = 0;
        nreq    = 0;
        done    = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_sel   = sel;
        bus.cmd_mem   = rd;
        bus.cmd_imm   = imm;
        bus.cmd_addr  = addr;
        bus.cmd_dst   = dst;
        bus.cmd_fmask = fmask;
        bus.cmd_valid = 1'b1;
        bus.mem_ack   = 1'b0;
        #1;
        chk("cmd_ready", bus.cmd_ready, 1);
        step();
        if (!hold) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_op    = ~op;
            bus.cmd_sel   = ~sel;
            bus.cmd_mem   = ~rd;
            bus.cmd_imm   = ~imm;
            bus.cmd_addr  = ~addr;
            bus.cmd_dst   = ~dst;
            bus.cmd_fmask = ~fmask;
        end
        for (int c = 2; c <= 64 && !done; c++) begin
            ack = 1'b0;
            if (bus.mem_req) begin
                nreq++;
                req_cnt++;
                if (lat != 0 && req_cnt == lat) begin
                    ack     = 1'b1;
                    req_cnt = 0;
                    if (q_mem.size() == 0) begin
                        chk("mem_req", bus.mem_req, 0);
                    end else begin
                        m = q_mem.pop_front();
                        chk("mem_we", bus.mem_we, m.we);
                        chk("mem_addr", bus.mem_addr, m.a);
                        if (m.we) chk("mem_wdata", bus.mem_wdata, m.d);
                    end
                end
            end else begin
                req_cnt = 0;
                ack     = noise;
            end
            bus.mem_ack   = ack;
            bus.mem_rdata = ack ? rdata : 8'hA5;
            #1;
            if (reg_we) begin
                if (q_reg.size() == 0) begin
                    chk("reg_we", reg_we, 0);
                end else begin
                    r = q_reg.pop_front();
                    chk("reg_waddr", reg_waddr, r.a);
                    chk("reg_wdata", reg_wdata, r.d);
                end
            end
            if (sr_we) begin
                if (q_sr.size() == 0) chk("sr_we", sr_we, 0);
                else chk("sr_wdata", sr_wdata, q_sr.pop_front());
            end
            if (bus.cmd_done) begin
                done = 1'b1;
                if (q_done.size() == 0) begin
                    chk("cmd_done", bus.cmd_done, 0);
                end else begin
                    d = q_done.pop_front();
                    chk("cmd_err", bus.cmd_err, d.err);
                    chk("done_cycle", c, d.cyc);
                end
            end else begin
                chk("busy_ready", bus.cmd_ready, 0);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        chk("done_seen", done, 1);
        chk("post_mem_req", bus.mem_req, 0);
        chk("post_ready", bus.cmd_ready, 1);
        chk("q_left", q_reg.size() + q_sr.size() +
                      q_mem.size() + q_done.size(), 0);
    endtask

    initial begin
        reset         = 1'b1;
        sr_in         = 8'h24;
        regs[0]       = 8'h00;
        regs[1]       = 8'h00;
        regs[2]       = 8'h00;
        regs[3]       = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_sel   = 2'd0;
        bus.cmd_mem   = 1'b0;
        bus.cmd_imm   = 8'd0;
        bus.cmd_addr  = 16'd0;
        bus.cmd_dst   = 3'd0;
        bus.cmd_fmask = 8'd0;
        bus.mem_rdata = 8'd0;
        bus.mem_ack   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_done", bus.cmd_done, 0);
        chk("rst_err", bus.cmd_err, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_sr_we", sr_we, 0);
        chk("rst_alu_op", alu_op, OP_TST);
        chk("rst_alu_din", alu_din, 0);

        // ADD imm to A, spurious mem_ack outside bus states
        regs[0] = 8'h50;
        sr_in   = 8'h24;
        q_reg.push_back('{2'd0, 8'hA0});
        q_sr.push_back(8'hE4);
        q_done.push_back('{1'b0, 3});
        run_cmd(OP_ADD, 2'd0, 1'b0, 8'h50, 16'h0000, DST_A, 8'hC3,
                2, 8'h00, 1'b0, 1'b1, n_req);

        // TST imm to S
        q_reg.push_back('{2'd3, 8'h80});
        q_sr.push_back(8'hA4);
        q_done.push_back('{1'b0, 3});
        run_cmd(OP_TST, 2'd1, 1'b0, 8'h80, 16'h0000, DST_S, 8'h82,
                2, 8'h00, 1'b0, 1'b0, n_req);

        // reserved destination: flags only, carry cleared by mask
        regs[0] = 8'h01;
        sr_in   = 8'h25;
        q_sr.push_back(8'h24);
        q_done.push_back('{1'b0, 3});
        run_cmd(OP_ADD, 2'd0, 1'b0, 8'h01, 16'h0000, 3'd7, 8'h03,
                2, 8'h00, 1'b0, 1'b0, n_req);

        // INC memory operand into X
        regs[0] = 8'hFF;
        sr_in   = 8'h24;
        q_mem.push_back('{1'b0, 16'h0010, 8'h00});
        q_reg.push_back('{2'd1, 8'h00});
        q_sr.push_back(8'h26);
        q_done.push_back('{1'b0, 5});
        run_cmd(OP_INC, 2'd0, 1'b1, 8'h00, 16'h0010, DST_X, 8'h82,
                2, 8'hFF, 1'b0, 1'b0, n_req);
        chk("alu_din_hold", alu_din, 8'hFF);
        chk("alu_op_hold", alu_op, OP_INC);

        // INC memory into Y with a slower bus
        q_mem.push_back('{1'b0, 16'h1234, 8'h00});
        q_reg.push_back('{2'd2, 8'h42});
        q_sr.push_back(8'h24);
        q_done.push_back('{1'b0, 6});
        run_cmd(OP_INC, 2'd2, 1'b1, 8'h00, 16'h1234, DST_Y, 8'hC3,
                3, 8'h41, 1'b0, 1'b0, n_req);

        // memory INC with result back to memory
        q_mem.push_back('{1'b0, 16'h0200, 8'h00});
`ifdef ALU_SEQ_RMW_EN
        q_mem.push_back('{1'b1, 16'h0200, 8'h7F});
        q_done.push_back('{1'b0, 9});
`else
        q_done.push_back('{1'b0, 7});
`endif
        q_mem.push_back('{1'b1, 16'h0200, 8'h80});
        q_sr.push_back(8'hA4);
        run_cmd(OP_INC, 2'd0, 1'b1, 8'h00, 16'h0200, DST_MEM, 8'hC3,
                2, 8'h7F, 1'b0, 1'b0, n_req);

        // ADD imm to memory: single write regardless of RMW
        regs[0] = 8'h80;
        q_sr.push_back(8'h67);
        q_mem.push_back('{1'b1, 16'h00FF, 8'h00});
        q_done.push_back('{1'b0, 5});
        run_cmd(OP_ADD, 2'd0, 1'b0, 8'h80, 16'h00FF, DST_MEM, 8'hC3,
                2, 8'h00, 1'b0, 1'b0, n_req);

        // bus never answers: abort after MEM_TMO cycles
        q_done.push_back('{1'b1, 1 + MEM_TMO});
        run_cmd(OP_TST, 2'd0, 1'b1, 8'h00, 16'h4321, DST_A, 8'hFF,
                0, 8'h00, 1'b0, 1'b0, n_req);
        chk("tmo_req_cycles", n_req, MEM_TMO);

        // fmask=0 and cmd_valid held across the busy window
        q_reg.push_back('{2'd0, 8'h00});
        q_done.push_back('{1'b0, 3});
        run_cmd(OP_TST, 2'd0, 1'b0, 8'h00, 16'h0000, DST_A, 8'h00,
                2, 8'h00, 1'b1, 1'b0, n_req);
        q_reg.push_back('{2'd0, 8'h00});
        q_done.push_back('{1'b0, 3});
        run_cmd(OP_TST, 2'd0, 1'b0, 8'h00, 16'h0000, DST_A, 8'h00,
                2, 8'h00, 1'b0, 1'b0, n_req);

        // reset while a read is outstanding
        bus.cmd_op    = OP_TST;
        bus.cmd_sel   = 2'd0;
        bus.cmd_mem   = 1'b1;
        bus.cmd_addr  = 16'h0300;
        bus.cmd_dst   = DST_A;
        bus.cmd_fmask = 8'hFF;
        bus.cmd_valid = 1'b1;
        #1;
        chk("rd_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        chk("rd_mem_req", bus.mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rd_done", bus.cmd_done, 0);
        step();
        chk("rstmid_mem_req", bus.mem_req, 0);
        chk("rstmid_ready", bus.cmd_ready, 1);
        chk("rstmid_done", bus.cmd_done, 0);
        reset = 1'b0;

        // normal operation resumes
        sr_in = 8'h24;
        q_reg.push_back('{2'd0, 8'h00});
        q_sr.push_back(8'h26);
        q_done.push_back('{1'b0, 3});
        run_cmd(OP_TST, 2'd0, 1'b0, 8'h00, 16'h0000, DST_A, 8'h02,
                2, 8'h00, 1'b0, 1'b0, n_req);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
